// File: rtl/param_counter.sv
// param_counter: modulo-MODULUS up/down counter with sync clear and clamped load; define PARAM_COUNTER_SATURATE_EN to saturate instead of wrap.
// Latency: one clock from any control to q/wrap; tc is combinational (zero latency).
// Backpressure: none; state advances on every enabled edge.
module param_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;

  // Increment/decrement only happen away from the limits, so no WIDTH-bit overflow is relied on.
  always_comb begin
    q_nxt    = q;
    wrap_nxt = 1'b0;
    if (clr) begin
      q_nxt = '0;
    end else if (load) begin
      q_nxt = (d > MAXV) ? MAXV : d;
    end else if (en) begin
      if (up) begin
        if (q == MAXV) begin
`ifdef PARAM_COUNTER_SATURATE_EN
          q_nxt = MAXV;
`else
          q_nxt    = '0;
          wrap_nxt = 1'b1;
`endif
        end else begin
          q_nxt = q + 1'b1;
        end
      end else begin
        if (q == '0) begin
`ifdef PARAM_COUNTER_SATURATE_EN
          q_nxt = '0;
`else
          q_nxt    = MAXV;
          wrap_nxt = 1'b1;
`endif
        end else begin
          q_nxt = q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      q    <= q_nxt;
      wrap <= wrap_nxt;
    end
  end

  assign tc = en & ((up & (q == MAXV)) | (~up & (q == '0)));

endmodule
